icache: RTL

Direct-mapped, read-only instruction cache on the fetch path between the program counter and the memory controller. Answers the fetch unit's `imemREN`/`imemaddr` requests with `ihit`/`imemload`; the PC advances only on `ihit`. On a miss, fills one frame from memory using a blocking `iREN`/`iwait` request. Write-free: instruction memory is never modified through this block.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types plus instruction-cache address/frame/state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBLKS  = 16;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signals of the instruction cache
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;

    // cache side
    modport slave (
        input  imemREN, imemaddr, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    // datapath + memory controller side
    modport master (
        output imemREN, imemaddr, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with blocking single-word fill
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = IBLKS
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  bus
);

    if (SETS != IBLKS) begin : g_sets_check
        $error("icache: SETS must match IBLKS from cpu_types_pkg");
    end

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;
    icache_frame_t frames_q [SETS];

    icachef_t      req_f, miss_f;
    icache_frame_t cur_frame;
    logic          fill_en;
    logic          ihit_c, iren_c;
    word_t         imemload_c, iaddr_c;
    logic          unused_bytoff;

    assign req_f         = icachef_t'(bus.imemaddr);
    assign miss_f        = icachef_t'(miss_addr_q);
    assign cur_frame     = frames_q[req_f.idx];
    assign unused_bytoff = ^{req_f.bytoff, miss_f.bytoff};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_en) begin
                frames_q[miss_f.idx] <= '{valid: 1'b1, tag: miss_f.tag, data: bus.iload};
            end
        end
    end

    // iREN/iaddr depend only on state_q/miss_addr_q, so an async reset drops them at once
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit_c      = 1'b0;
        imemload_c  = '0;
        iren_c      = 1'b0;
        iaddr_c     = '0;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.imemREN && cur_frame.valid && (cur_frame.tag == req_f.tag)) begin
                    ihit_c     = 1'b1;
                    imemload_c = cur_frame.data;
                end else if (bus.imemREN) begin
                    miss_addr_d = {bus.imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                iren_c  = 1'b1;
                iaddr_c = miss_addr_q;
                if (!bus.iwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ihit     = ihit_c;
    assign bus.imemload = imemload_c;
    assign bus.iREN     = iren_c;
    assign bus.iaddr    = iaddr_c;

endmodule
